// File: rtl/data_cache_pkg.sv
// Shared definitions for the data cache: FSM state encoding and default counter width.
package data_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR_THRU = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/data_cache_if.sv
// CPU-side request bus and backing-memory bus of the data cache.
interface data_cache_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 16
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // Cache side
  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_stall, mem_rd, mem_wr, mem_addr, mem_wdata
  );

  // CPU / backing-memory side
  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_stall, mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_cache_line_store.sv
// Direct-mapped line store: valid/tag/data arrays, combinational lookup, single write port.
module data_cache_line_store #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LINES  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_lk_addr,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_rdata,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wdata
);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W;

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [IDX_W-1:0] w_wr_idx;
  logic [TAG_W-1:0] w_wr_tag;

  assign w_lk_idx = i_lk_addr[IDX_W-1:0];
  assign w_lk_tag = i_lk_addr[ADDR_W-1:IDX_W];
  assign w_wr_idx = i_wr_addr[IDX_W-1:0];
  assign w_wr_tag = i_wr_addr[ADDR_W-1:IDX_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  // A write hit rewrites the same tag, so fills and write hits share one port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[w_wr_idx]  <= w_wr_tag;
      r_data[w_wr_idx] <= i_wdata;
    end
  end

  assign o_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign o_rdata = r_data[w_lk_idx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with saturating read hit/miss counters.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LINES  = 16,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  data_cache_if.slave      bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  state_t r_state, w_next;

  logic              r_mem_rd, r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rd_buf;
  logic              r_is_rd;
  logic [CNT_W-1:0]  r_hit_cnt, r_miss_cnt;

  logic              w_hit;
  logic [DATA_W-1:0] w_line_data;
  logic              w_we;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_stall;
  logic [DATA_W-1:0] w_rdata;
  logic              w_rd_hit;
  logic              w_rd_miss;

  data_cache_line_store #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LINES  (LINES)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .i_lk_addr (bus.cpu_addr),
    .o_hit     (w_hit),
    .o_rdata   (w_line_data),
    .i_we      (w_we),
    .i_wr_addr (w_wr_addr),
    .i_wdata   (w_wdata)
  );

  assign w_rd_hit  = (r_state == ST_IDLE) && bus.cpu_rd && !bus.cpu_wr && w_hit;
  assign w_rd_miss = (r_state == ST_IDLE) && bus.cpu_rd && !bus.cpu_wr && !w_hit;

  always_comb begin
    w_next    = r_state;
    w_stall   = 1'b0;
    w_rdata   = '0;
    w_we      = 1'b0;
    w_wr_addr = bus.cpu_addr;
    w_wdata   = bus.cpu_wdata;
    case (r_state)
      ST_IDLE: begin
        if (bus.cpu_wr) begin
          w_stall = 1'b1;
          w_we    = w_hit;
          w_next  = ST_WR_THRU;
        end else if (bus.cpu_rd) begin
          if (w_hit) begin
            w_rdata = w_line_data;
          end else begin
            w_stall = 1'b1;
            w_next  = ST_RD_MISS;
          end
        end
      end
      ST_RD_MISS: begin
        w_stall = 1'b1;
        if (bus.mem_ack) begin
          w_we      = 1'b1;
          w_wr_addr = r_mem_addr;
          w_wdata   = bus.mem_rdata;
          w_next    = ST_DONE;
        end
      end
      ST_WR_THRU: begin
        w_stall = 1'b1;
        if (bus.mem_ack) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_rdata = r_is_rd ? r_rd_buf : '0;
        w_next  = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_buf    <= '0;
      r_is_rd     <= 1'b0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_state  <= w_next;
      // Strobes follow the next state so they are registered and mutually exclusive.
      r_mem_rd <= (w_next == ST_RD_MISS);
      r_mem_wr <= (w_next == ST_WR_THRU);
      if ((r_state == ST_IDLE) && (bus.cpu_rd || bus.cpu_wr)) begin
        r_mem_addr <= bus.cpu_addr;
        r_is_rd    <= !bus.cpu_wr;
        if (bus.cpu_wr) r_mem_wdata <= bus.cpu_wdata;
      end
      if ((r_state == ST_RD_MISS) && bus.mem_ack) r_rd_buf <= bus.mem_rdata;
      if (w_rd_hit && (r_hit_cnt != '1))   r_hit_cnt  <= r_hit_cnt + 1'b1;
      if (w_rd_miss && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign bus.cpu_stall = w_stall;
  assign bus.cpu_rdata = w_rdata;
  assign bus.mem_rd    = r_mem_rd;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign hit_cnt       = r_hit_cnt;
  assign miss_cnt      = r_miss_cnt;

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: directed cases, random traffic and a reset-mid-miss abort.
module tb_data_cache;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 16;
  localparam int unsigned LN = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] hit_cnt, miss_cnt;

  data_cache_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_cache #(.ADDR_W(AW), .DATA_W(DW), .LINES(LN), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   lat;
  } exp_t;

  exp_t sb[$];

  // Reference model: what the memory should hold, and which address each line holds.
  logic [DW-1:0] ref_mem   [64];
  logic [DW-1:0] mem_store [64];
  int            resident  [LN];
  int unsigned   m_hits = 0, m_miss = 0;

  int unsigned   mem_wait = 0;
  logic          mem_busy_ok = 1'b0;
  logic          exp_is_wr = 1'b0;
  logic [AW-1:0] exp_maddr = '0;
  logic [DW-1:0] exp_mwdata = '0;

  // Backing memory: ack after mem_wait cycles of a pending request
  initial begin
    int unsigned cnt;
    cnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (!rst && !mem_busy_ok)
        check("mem_idle", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
      if (bus.mem_rd || bus.mem_wr) begin
        if (cnt == mem_wait) begin
          check("mem_excl", {31'd0, bus.mem_rd & bus.mem_wr}, 32'd0);
          check("mem_dir", {31'd0, bus.mem_wr}, {31'd0, exp_is_wr});
          check("mem_addr", bus.mem_addr, exp_maddr);
          if (bus.mem_wr) begin
            check("mem_wdata", {16'd0, bus.mem_wdata}, {16'd0, exp_mwdata});
            mem_store[bus.mem_addr[5:0]] = bus.mem_wdata;
          end else begin
            bus.mem_rdata = mem_store[bus.mem_addr[5:0]];
          end
          bus.mem_ack = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: pops one expectation per completed request
  initial begin
    int unsigned lat;
    exp_t e;
    lat = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        lat = 0;
      end else if (bus.cpu_rd || bus.cpu_wr) begin
        if (bus.cpu_stall) begin
          lat++;
        end else begin
          check("sb_size", sb.size(), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rdata", {16'd0, bus.cpu_rdata}, {16'd0, e.data});
            check("latency", lat, e.lat);
          end
          lat = 0;
        end
      end else begin
        lat = 0;
      end
    end
  end

  task automatic do_req(input logic wr, input logic rd, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int unsigned w);
    exp_t e;
    bit   hit;
    bit   done;
    int   idx;
    @(posedge clk);
    #1;
    idx = int'(a % LN);
    hit = !wr && (resident[idx] == int'(a));
    if (wr) begin
      e.data = '0;
      e.lat  = 2 + w;
      ref_mem[a[5:0]] = d;
    end else if (hit) begin
      e.data = ref_mem[a[5:0]];
      e.lat  = 0;
      if (m_hits < CMAX) m_hits++;
    end else begin
      e.data = ref_mem[a[5:0]];
      e.lat  = 2 + w;
      resident[idx] = int'(a);
      if (m_miss < CMAX) m_miss++;
    end
    mem_wait    = w;
    mem_busy_ok = !hit;
    exp_is_wr   = wr;
    exp_maddr   = a;
    exp_mwdata  = d;
    sb.push_back(e);
    bus.cpu_wr    = wr;
    bus.cpu_rd    = wr ? rd : 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.cpu_stall) begin
        done = 1'b1;
        break;
      end
    end
    check("complete", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    bus.cpu_rd  = 1'b0;
    bus.cpu_wr  = 1'b0;
    mem_busy_ok = 1'b0;
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_miss);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] v;
    logic          wr;
    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      v = DW'($urandom);
      ref_mem[i]   = v;
      mem_store[i] = v;
    end
    ref_mem[5]   = 16'hBEEF;
    mem_store[5] = 16'hBEEF;
    for (int i = 0; i < int'(LN); i++) resident[i] = -1;

    #1;
    check("rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
    check("rst_rdata", {16'd0, bus.cpu_rdata}, 32'd0);
    check("rst_mem_strobes", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    do_req(1'b0, 1'b1, 32'h05, 16'h0, 3);       // miss, 5 stall cycles
    do_req(1'b0, 1'b1, 32'h05, 16'h0, 0);       // hit
    do_req(1'b0, 1'b1, 32'h15, 16'h0, 1);       // evicts 0x05
    do_req(1'b0, 1'b1, 32'h05, 16'h0, 2);       // misses again
    do_req(1'b0, 1'b1, 32'h15, 16'h0, 0);       // re-cache 0x15
    do_req(1'b1, 1'b0, 32'h15, 16'hCAFE, 2);    // write hit
    do_req(1'b0, 1'b1, 32'h15, 16'h0, 0);       // hit with 0xCAFE
    do_req(1'b1, 1'b1, 32'h22, 16'h1234, 1);    // write miss, write wins over read
    do_req(1'b0, 1'b1, 32'h22, 16'h0, 1);       // no allocate: miss

    for (int n = 0; n < 250; n++) begin
      wr = ($urandom_range(0, 2) == 0);
      do_req(wr, 1'($urandom), AW'($urandom_range(0, 47)), DW'($urandom),
             $urandom_range(0, 3));
    end

    // Abort a read miss with reset
    do_req(1'b0, 1'b1, 32'h15, 16'h0, 0);
    do_req(1'b0, 1'b1, 32'h23, 16'h0, 0);
    @(posedge clk);
    #1;
    mem_wait      = 20;
    mem_busy_ok   = 1'b1;
    exp_is_wr     = 1'b0;
    exp_maddr     = 32'h33;
    bus.cpu_rd    = 1'b1;
    bus.cpu_addr  = 32'h33;
    repeat (3) @(negedge clk);
    #2;
    rst        = 1'b1;
    bus.cpu_rd = 1'b0;
    #1;
    check("abort_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    check("abort_stall", {31'd0, bus.cpu_stall}, 32'd0);
    check("abort_hit_cnt", hit_cnt, 32'd0);
    check("abort_miss_cnt", miss_cnt, 32'd0);
    mem_busy_ok = 1'b0;
    for (int i = 0; i < int'(LN); i++) resident[i] = -1;
    m_hits = 0;
    m_miss = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    do_req(1'b0, 1'b1, 32'h15, 16'h0, 1);       // valids cleared: miss
    do_req(1'b0, 1'b1, 32'h15, 16'h0, 0);       // now hit

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
